rtc_display_latch: RTL and testbench
====================================

Name: rtc_display_latch

Overview:
- Frame-synchronous data stage directly upstream of the VGA top.
- Accepts byte writes of RTC/date/timer BCD values from the RTC read/program FSM into a shadow bank.
- Commits the shadow bank to a display bank only at a vsync frame boundary, so the number renderers never see a half-updated value mid-frame.
- Generates the level alarm request that drives the on-screen ring graphic when the countdown timer reaches 00:00:00.

Parameters:
- VSYNC_ACTIVE_LOW, 1, polarity of the vsync input; commit happens on the assertion edge.
- ALARM_FRAMES, 600, number of frame edges the alarm stays asserted without an ack (about 10 s at 60 Hz).
- FCNT_W, 10, width of the alarm frame counter; must satisfy 2^FCNT_W > ALARM_FRAMES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  write strobe from the RTC FSM
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  4  0-2 hour1..3, 3-5 fecha1..3, 6-8 timer1..3; 9-15 ignored
- wr_data  in  8  packed BCD byte
- wr_last  in  1  marks the final write of a burst; requests a commit
- vsync  in  1  from the sync generator
- alarm_arm  in  1  level; enables timer-expiry detection
- alarm_ack  in  1  single-cycle pulse; clears the alarm
- hour_out1..3  out  8 each  committed hour bytes
- fecha_out1..3  out  8 each  committed date bytes
- timer_out1..3  out  8 each  committed timer bytes
- activar_alarma  out  1  alarm request to the display
- commit_pending  out  1  a burst is waiting for the next frame edge
- bcd_err  out  1  sticky; present only with BCD_CHECK_EN, otherwise tied to 0

Behaviour:
- Reset: all shadow and display bytes = 0x00; activar_alarma = 0; commit_pending = 0; bcd_err = 0; frame counter = 0; vsync_q = inactive level.
  - The inactive level means no false edge is seen on the first cycle after reset.
- Frame edge detection:
  - vsync_q registers vsync every clk.
  - frame_edge (combinational) = vsync is active and vsync_q is inactive.
- wr_ready = !frame_edge. A write presented while wr_ready = 0 is not accepted: no shadow update, and its wr_last is ignored. The source must hold the write.
- Accepted write:
  - Shadow[wr_addr] <= wr_data on the next edge.
  - Addresses 9-15 are accepted, but the data is discarded.
  - If wr_last is also set, commit_pending <= 1.
- Commit:
  - On a frame_edge cycle with commit_pending = 1, all nine display bytes <= shadow bytes, and commit_pending <= 0.
  - Display outputs change 1 clk after the frame_edge cycle.
  - frame_edge with commit_pending = 0: the display is unchanged.
- Writes between commits only affect the shadow bank. Multiple bursts before one edge: the last values win, and there is a single commit.
- Alarm trigger:
  - Fires in a commit cycle where alarm_arm = 1, the new timer bytes are all 0x00, and the current display timer is not all 0x00.
  - Effect: activar_alarma <= 1 and frame counter <= 0.
  - Committing zero onto an already-zero timer never triggers.
- Alarm hold:
  - While activar_alarma = 1, each frame_edge increments the counter.
  - When the counter reaches ALARM_FRAMES-1 on a frame_edge, activar_alarma <= 0.
  - alarm_ack = 1 clears activar_alarma and the counter on the next edge.
  - ack has priority over a simultaneous trigger.
  - alarm_arm dropping to 0 clears activar_alarma on the next edge.
- The counter saturates and never wraps while the alarm is active.
- Reset mid-burst or mid-alarm: everything returns to reset values, and the pending commit is lost.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - An accepted write to addresses 0-8 with either nibble > 9 is dropped: the shadow is unchanged, and wr_last still sets commit_pending.
  - bcd_err <= 1 (sticky until reset).
- Undefined: all bytes are stored unchecked, and bcd_err is constant 0.

Decomposition:
- Shared package holds:
  - the address constants (ADDR_HOUR1 .. ADDR_TIMER3 = 0..8);
  - the BCD byte typedef;
  - the default ALARM_FRAMES.
- One natural sub-module: frame_edge_det, which holds the vsync register, applies the polarity parameter, and outputs frame_edge.
- Shadow/display banks and the alarm FSM stay in the top.
  - Alarm FSM states: IDLE and RINGING.

Test Plan:
- Write burst, no vsync: write 0x12, 0x34, 0x56 to addr 0-2, last on the third write -> hour_out stays 0x00 and commit_pending = 1; after a vsync falling edge, hour_out = 12/34/56 one clk later and commit_pending = 0.
- Collision: assert wr_valid with addr 1, data 0x59, wr_last in the frame_edge cycle -> wr_ready = 0 and no accept; held one more cycle -> accepted; commit only on the next frame.
- Timer expiry: display timer 00/00/01, alarm_arm = 1, commit 00/00/00 -> activar_alarma = 1 one clk after the edge; deasserts after 600 frame edges with no ack.
- Ack: with the alarm ringing, pulse alarm_ack -> activar_alarma = 0 next clk; a second commit of 00/00/00 -> no re-trigger.
- Reset during ringing, with commit_pending = 1 -> all outputs 0x00 and activar_alarma = 0; the next vsync edge changes nothing.
- BCD_CHECK_EN: write 0x3A to addr 4 -> fecha_out2 keeps its old value and bcd_err = 1; without the macro, 0x3A is committed and bcd_err = 0.

Source files
------------

// File: rtl/rtc_display_latch_pkg.sv
// Shared types and constants for the RTC display latch: register map, BCD byte type,
// alarm FSM states and the default alarm hold length.
package rtc_display_latch_pkg;

  typedef logic [7:0] bcd_t;
  typedef logic [3:0] addr_t;

  localparam addr_t ADDR_HOUR1  = 4'd0;
  localparam addr_t ADDR_HOUR2  = 4'd1;
  localparam addr_t ADDR_HOUR3  = 4'd2;
  localparam addr_t ADDR_FECHA1 = 4'd3;
  localparam addr_t ADDR_FECHA2 = 4'd4;
  localparam addr_t ADDR_FECHA3 = 4'd5;
  localparam addr_t ADDR_TIMER1 = 4'd6;
  localparam addr_t ADDR_TIMER2 = 4'd7;
  localparam addr_t ADDR_TIMER3 = 4'd8;

  localparam int unsigned NumRegs            = 9;
  localparam int unsigned DefaultAlarmFrames = 600;

  typedef enum logic {StIdle, StRinging} alarm_state_e;

  function automatic logic is_bcd(bcd_t b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_display_latch_if.sv
// Byte-write channel from the RTC read/program FSM into the display latch shadow bank.
interface rtc_display_latch_if;
  import rtc_display_latch_pkg::*;

  logic  wr_valid;
  logic  wr_ready;
  addr_t wr_addr;
  bcd_t  wr_data;
  logic  wr_last;

  modport master (output wr_valid, output wr_addr, output wr_data, output wr_last,
                  input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, input wr_last,
                  output wr_ready);

endinterface

// File: rtl/rtc_display_latch_frame_edge_det.sv
// Registers vsync and flags the cycle in which it moves to its active level.
module rtc_display_latch_frame_edge_det #(
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic frame_edge
);

  // Resetting to the idle level keeps the first post-reset cycle from looking like an edge.
  localparam logic InactiveLevel = VSYNC_ACTIVE_LOW;

  logic vsync_d, vsync_q;

  always_comb begin
    vsync_d = vsync;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= InactiveLevel;
    end else begin
      vsync_q <= vsync_d;
    end
  end

  assign frame_edge = (vsync != InactiveLevel) && (vsync_q == InactiveLevel);

endmodule

// File: rtl/rtc_display_latch.sv
// Shadow/display double bank for RTC, date and timer bytes, committed on vsync, plus the
// timer-expiry alarm. Define BCD_CHECK_EN to drop non-BCD writes and raise sticky bcd_err.
module rtc_display_latch
  import rtc_display_latch_pkg::*;
#(
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned ALARM_FRAMES     = DefaultAlarmFrames,
  parameter int unsigned FCNT_W           = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  rtc_display_latch_if.slave   wr,
  input  logic                 vsync,
  input  logic                 alarm_arm,
  input  logic                 alarm_ack,
  output bcd_t                 hour_out1,
  output bcd_t                 hour_out2,
  output bcd_t                 hour_out3,
  output bcd_t                 fecha_out1,
  output bcd_t                 fecha_out2,
  output bcd_t                 fecha_out3,
  output bcd_t                 timer_out1,
  output bcd_t                 timer_out2,
  output bcd_t                 timer_out3,
  output logic                 activar_alarma,
  output logic                 commit_pending,
  output logic                 bcd_err
);

  logic frame_edge;

  rtc_display_latch_frame_edge_det #(
    .VSYNC_ACTIVE_LOW (VSYNC_ACTIVE_LOW)
  ) u_frame_edge_det (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .frame_edge (frame_edge)
  );

  bcd_t         shadow_d [NumRegs];
  bcd_t         shadow_q [NumRegs];
  bcd_t         disp_d   [NumRegs];
  bcd_t         disp_q   [NumRegs];
  logic         pend_d, pend_q;
  alarm_state_e state_d, state_q;
  logic [FCNT_W-1:0] fcnt_d, fcnt_q;

  logic wr_ready, accept, data_ok, commit, new_zero, cur_zero, trigger;

  // Writes are refused only in the commit cycle so the shadow is stable while it is copied.
  assign wr_ready    = !frame_edge;
  assign wr.wr_ready = wr_ready;
  assign accept      = wr.wr_valid && wr_ready;
  assign commit      = frame_edge && pend_q;

`ifdef BCD_CHECK_EN
  assign data_ok = is_bcd(wr.wr_data);
`else
  assign data_ok = 1'b1;
`endif

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NumRegs; i++) begin
      if (accept && data_ok && (wr.wr_addr == 4'(i))) begin
        shadow_d[i] = wr.wr_data;
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (accept && wr.wr_last) begin
      pend_d = 1'b1;
    end else if (commit) begin
      pend_d = 1'b0;
    end
  end

  always_comb begin
    disp_d = disp_q;
    if (commit) begin
      disp_d = shadow_q;
    end
  end

  assign new_zero = (shadow_q[ADDR_TIMER1] == 8'h00) && (shadow_q[ADDR_TIMER2] == 8'h00) &&
                    (shadow_q[ADDR_TIMER3] == 8'h00);
  assign cur_zero = (disp_q[ADDR_TIMER1] == 8'h00) && (disp_q[ADDR_TIMER2] == 8'h00) &&
                    (disp_q[ADDR_TIMER3] == 8'h00);
  // Only a nonzero -> zero transition counts as expiry.
  assign trigger  = commit && alarm_arm && new_zero && !cur_zero;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (alarm_ack || !alarm_arm) begin
      state_d = StIdle;
      fcnt_d  = '0;
    end else if (trigger) begin
      state_d = StRinging;
      fcnt_d  = '0;
    end else if ((state_q == StRinging) && frame_edge) begin
      if (fcnt_q >= FCNT_W'(ALARM_FRAMES - 1)) begin
        state_d = StIdle;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      disp_q   <= '{default: '0};
      pend_q   <= 1'b0;
      state_q  <= StIdle;
      fcnt_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
    end
  end

`ifdef BCD_CHECK_EN
  logic bcd_err_d, bcd_err_q;

  always_comb begin
    bcd_err_d = bcd_err_q;
    if (accept && (wr.wr_addr <= ADDR_TIMER3) && !data_ok) begin
      bcd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_err_q <= 1'b0;
    end else begin
      bcd_err_q <= bcd_err_d;
    end
  end

  assign bcd_err = bcd_err_q;
`else
  assign bcd_err = 1'b0;
`endif

  assign hour_out1      = disp_q[ADDR_HOUR1];
  assign hour_out2      = disp_q[ADDR_HOUR2];
  assign hour_out3      = disp_q[ADDR_HOUR3];
  assign fecha_out1     = disp_q[ADDR_FECHA1];
  assign fecha_out2     = disp_q[ADDR_FECHA2];
  assign fecha_out3     = disp_q[ADDR_FECHA3];
  assign timer_out1     = disp_q[ADDR_TIMER1];
  assign timer_out2     = disp_q[ADDR_TIMER2];
  assign timer_out3     = disp_q[ADDR_TIMER3];
  assign activar_alarma = (state_q == StRinging);
  assign commit_pending = pend_q;

endmodule

// File: tb/tb_rtc_display_latch.sv
// Directed bench for rtc_display_latch: vector table for write/commit timing plus hand
// sequences for alarm expiry, ack, reset and the optional BCD check.
module tb_rtc_display_latch;
  import rtc_display_latch_pkg::*;

  logic clk = 1'b0;
  logic reset, vsync, alarm_arm, alarm_ack;
  bcd_t hour_out1, hour_out2, hour_out3;
  bcd_t fecha_out1, fecha_out2, fecha_out3;
  bcd_t timer_out1, timer_out2, timer_out3;
  logic activar_alarma, commit_pending, bcd_err;

  int n_cmp = 0;
  int n_err = 0;

  rtc_display_latch_if wr_if ();

  rtc_display_latch dut (
    .clk            (clk),
    .reset          (reset),
    .wr             (wr_if.slave),
    .vsync          (vsync),
    .alarm_arm      (alarm_arm),
    .alarm_ack      (alarm_ack),
    .hour_out1      (hour_out1),
    .hour_out2      (hour_out2),
    .hour_out3      (hour_out3),
    .fecha_out1     (fecha_out1),
    .fecha_out2     (fecha_out2),
    .fecha_out3     (fecha_out3),
    .timer_out1     (timer_out1),
    .timer_out2     (timer_out2),
    .timer_out3     (timer_out3),
    .activar_alarma (activar_alarma),
    .commit_pending (commit_pending),
    .bcd_err        (bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [3:0] addr;
    logic [7:0] data;
    logic       last;
    logic       vs;
    logic       exp_ready;
    logic       exp_pend;
    logic [7:0] h1;
    logic [7:0] h2;
    logic [7:0] h3;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data, input logic last);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = addr;
    wr_if.wr_data  = data;
    wr_if.wr_last  = last;
    @(posedge clk);
    #1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
  endtask

  task automatic frame();
    vsync = 1'b0;
    @(posedge clk);
    #1;
    vsync = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    bcd_t outs [9];
    outs = '{hour_out1, hour_out2, hour_out3, fecha_out1, fecha_out2, fecha_out3,
             timer_out1, timer_out2, timer_out3};
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s_out%0d", tag, i), 32'(outs[i]), 32'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    //          valid addr  data   last vs  rdy  pend  h1     h2     h3
    vecs[0]  = '{1'b1, 4'd0, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 4'd1, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 4'd2, 8'h56, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56};
    vecs[5]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56};
    vecs[6]  = '{1'b1, 4'd1, 8'h59, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56};
    vecs[7]  = '{1'b1, 4'd1, 8'h59, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56};
    vecs[8]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56};
    vecs[9]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56};
    vecs[10] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'h59, 8'h56};
    vecs[11] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h59, 8'h56};
    vecs[12] = '{1'b1, 4'd0, 8'h21, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h59, 8'h56};
    vecs[13] = '{1'b1, 4'd0, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h59, 8'h56};
    vecs[14] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 8'h59, 8'h56};
    vecs[15] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 8'h59, 8'h56};
    vecs[16] = '{1'b1, 4'd9, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h59, 8'h56};
    vecs[17] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 8'h59, 8'h56};
    vecs[18] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 8'h59, 8'h56};
    vecs[19] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 8'h59, 8'h56};
    vecs[20] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 8'h59, 8'h56};

    reset          = 1'b1;
    vsync          = 1'b1;
    alarm_arm      = 1'b0;
    alarm_ack      = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = 4'd0;
    wr_if.wr_data  = 8'h00;
    wr_if.wr_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk_all_zero("reset");
    chk("reset_alarm", 32'(activar_alarma), 32'd0);
    chk("reset_pend", 32'(commit_pending), 32'd0);
    chk("reset_bcd_err", 32'(bcd_err), 32'd0);
    chk("reset_ready", 32'(wr_if.wr_ready), 32'd1);

    // Cycle-by-cycle write/commit table: burst, collision, multi-burst, ignored address.
    for (int i = 0; i < 21; i++) begin
      wr_if.wr_valid = vecs[i].valid;
      wr_if.wr_addr  = vecs[i].addr;
      wr_if.wr_data  = vecs[i].data;
      wr_if.wr_last  = vecs[i].last;
      vsync          = vecs[i].vs;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(wr_if.wr_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pend", i), 32'(commit_pending), 32'(vecs[i].exp_pend));
      chk($sformatf("vec%0d_h1", i), 32'(hour_out1), 32'(vecs[i].h1));
      chk($sformatf("vec%0d_h2", i), 32'(hour_out2), 32'(vecs[i].h2));
      chk($sformatf("vec%0d_h3", i), 32'(hour_out3), 32'(vecs[i].h3));
    end
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    vsync          = 1'b1;

    // Timer expiry and the full hold time with no ack.
    alarm_arm = 1'b1;
    wr(4'd6, 8'h00, 1'b0);
    wr(4'd7, 8'h00, 1'b0);
    wr(4'd8, 8'h01, 1'b1);
    frame();
    chk("timer_load_t3", 32'(timer_out3), 32'h01);
    chk("timer_load_alarm", 32'(activar_alarma), 32'd0);
    wr(4'd8, 8'h00, 1'b1);
    vsync = 1'b0;
    @(posedge clk);
    #1;
    chk("expiry_alarm_set", 32'(activar_alarma), 32'd1);
    chk("expiry_t3", 32'(timer_out3), 32'h00);
    vsync = 1'b1;
    @(posedge clk);
    #1;
    repeat (599) frame();
    chk("alarm_hold_599", 32'(activar_alarma), 32'd1);
    frame();
    chk("alarm_expire_600", 32'(activar_alarma), 32'd0);

    // Ack clears; committing zero onto zero must not re-trigger.
    wr(4'd8, 8'h02, 1'b1);
    frame();
    chk("nonzero_no_alarm", 32'(activar_alarma), 32'd0);
    wr(4'd8, 8'h00, 1'b1);
    frame();
    chk("retrigger", 32'(activar_alarma), 32'd1);
    alarm_ack = 1'b1;
    @(posedge clk);
    #1;
    alarm_ack = 1'b0;
    chk("ack_clear", 32'(activar_alarma), 32'd0);
    wr(4'd8, 8'h00, 1'b1);
    frame();
    chk("zero_on_zero", 32'(activar_alarma), 32'd0);

    // Dropping alarm_arm clears a ringing alarm.
    wr(4'd8, 8'h03, 1'b1);
    frame();
    wr(4'd8, 8'h00, 1'b1);
    frame();
    chk("arm_ring", 32'(activar_alarma), 32'd1);
    alarm_arm = 1'b0;
    @(posedge clk);
    #1;
    chk("arm_drop", 32'(activar_alarma), 32'd0);
    alarm_arm = 1'b1;

    // Ack in the very commit cycle that would trigger wins.
    wr(4'd8, 8'h04, 1'b1);
    frame();
    wr(4'd8, 8'h00, 1'b1);
    vsync     = 1'b0;
    alarm_ack = 1'b1;
    @(posedge clk);
    #1;
    alarm_ack = 1'b0;
    chk("ack_priority", 32'(activar_alarma), 32'd0);
    chk("ack_priority_t3", 32'(timer_out3), 32'h00);
    vsync = 1'b1;
    @(posedge clk);
    #1;

    // Reset while ringing with a pending commit.
    wr(4'd8, 8'h05, 1'b1);
    frame();
    wr(4'd8, 8'h00, 1'b1);
    frame();
    chk("pre_reset_ring", 32'(activar_alarma), 32'd1);
    wr(4'd0, 8'h99, 1'b1);
    chk("pre_reset_pend", 32'(commit_pending), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all_zero("midreset");
    chk("midreset_alarm", 32'(activar_alarma), 32'd0);
    chk("midreset_pend", 32'(commit_pending), 32'd0);
    frame();
    chk_all_zero("postreset_frame");
    chk("postreset_alarm", 32'(activar_alarma), 32'd0);

    // Non-BCD byte handling.
    wr(4'd4, 8'h15, 1'b1);
    frame();
    chk("fecha2_load", 32'(fecha_out2), 32'h15);
    wr(4'd4, 8'h3A, 1'b1);
    chk("bad_bcd_pend", 32'(commit_pending), 32'd1);
    frame();
`ifdef BCD_CHECK_EN
    chk("bad_bcd_fecha2", 32'(fecha_out2), 32'h15);
    chk("bad_bcd_err", 32'(bcd_err), 32'd1);
`else
    chk("bad_bcd_fecha2", 32'(fecha_out2), 32'h3A);
    chk("bad_bcd_err", 32'(bcd_err), 32'd0);
`endif
    chk("bad_bcd_pend_clear", 32'(commit_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
